// File: rtl/regfile_context_engine.sv
// regfile_context_engine: drives the register file's read port A and write port.
// SAVE streams registers FIRST_REG..NUM_REGS-1 out over a valid/ready channel.
// RESTORE writes an incoming valid/ready stream back in ascending order.
module regfile_context_engine #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIRST_REG  = 1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  start_save,
  input  logic                  start_restore,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  output logic                  ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic                  save_valid,
  output logic [DATA_WIDTH-1:0] save_data,
  output logic [ADDR_WIDTH-1:0] save_addr,
  input  logic                  save_ready,
  input  logic                  restore_valid,
  input  logic [DATA_WIDTH-1:0] restore_data,
  output logic                  restore_ready
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_RD,
    SAVE_OUT,
    RESTORE,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   save_data_q;
  logic [ADDR_WIDTH-1:0]   save_addr_q;
  logic                    at_last;
  logic                    save_fire;
  logic                    restore_fire;

  assign at_last      = (ptr == LAST_IDX);
  assign save_fire    = (state == SAVE_OUT) && save_ready && !abort;
  // abort suppresses the write even if the producer completes a handshake
  assign restore_fire = (state == RESTORE) && restore_valid && !abort;

  // State register
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; save wins when both starts arrive together
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_save) begin
          next_state = SAVE_RD;
        end else if (start_restore) begin
          next_state = RESTORE;
        end
      end
      SAVE_RD: begin
        next_state = abort ? IDLE : SAVE_OUT;
      end
      SAVE_OUT: begin
        if (abort) begin
          next_state = IDLE;
        end else if (save_ready) begin
          next_state = at_last ? DONE : SAVE_RD;
        end
      end
      RESTORE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (restore_valid && at_last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Register pointer: reloads on start, advances after each accepted beat, stops at the last register
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ptr <= FIRST_IDX;
    end else begin
      case (state)
        IDLE: begin
          if (start_save || start_restore) begin
            ptr <= FIRST_IDX;
          end
        end
        SAVE_OUT: begin
          if (save_fire && !at_last) begin
            ptr <= ptr + 1'b1;
          end
        end
        RESTORE: begin
          if (restore_fire && !at_last) begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Capture the read-port value so the save beat stays stable while stalled
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      save_data_q <= '0;
      save_addr_q <= '0;
    end else if (state == SAVE_RD) begin
      save_data_q <= data_readRegA;
      save_addr_q <= ptr;
    end
  end

  // Outputs decoded from state; ports are released (driven to zero) when not in use
  always_comb begin
    busy             = (state == SAVE_RD) || (state == SAVE_OUT) || (state == RESTORE);
    done             = (state == DONE);
    ctrl_readRegA    = (state == SAVE_RD) ? ptr : '0;
    save_valid       = (state == SAVE_OUT);
    save_data        = save_data_q;
    save_addr        = save_addr_q;
    restore_ready    = (state == RESTORE);
    ctrl_writeEnable = restore_fire;
    ctrl_writeReg    = restore_fire ? ptr : '0;
    data_writeReg    = restore_fire ? restore_data : '0;
  end

endmodule
